// File: rtl/warmboot_pkg.sv
// Shared types and constants for the warm-boot reset sequencer / image selector.
package warmboot_pkg;

    typedef enum logic [2:0] {
        LOCK_WAIT = 3'd0,
        RST_HOLD  = 3'd1,
        RUN       = 3'd2,
        COUNTDOWN = 3'd3,
        BOOT      = 3'd4
    } wb_state_e;

    localparam logic [1:0] SLOT_SPRINGBOARD = 2'd0;
    localparam logic [1:0] SLOT_DFU         = 2'd1;
    localparam logic [1:0] SLOT_USER        = 2'd2;

    // Bits needed to hold 0..max_val; a zero-valued parameter still gets one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/warmboot_ctrl_sync_2ff.sv
// Two-flop synchroniser that brings the asynchronous PLL lock into the clk domain.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/warmboot_ctrl.sv
// Reset sequencer and SB_WARMBOOT image selector; the optional watchdog trigger
// is compiled in only when WARMBOOT_WDT_EN is defined.
//
// state     | meaning
// LOCK_WAIT | waiting for synchronised PLL lock, sys_rst held
// RST_HOLD  | lock seen, counting RST_DELAY before releasing sys_rst
// RUN       | system running, watching for boot triggers
// COUNTDOWN | slot latched on wb_s, counting BOOT_DELAY
// BOOT      | wb_boot asserted, terminal until rst_n
module warmboot_ctrl
    import warmboot_pkg::*;
#(
    parameter int         RST_DELAY      = 255,
    parameter int         USB_RST_CYCLES = 16,
    parameter int         BOOT_DELAY     = 64,
    parameter logic [1:0] USB_SLOT       = SLOT_USER,
    parameter int         WDT_CYCLES     = 1 << 20,
    parameter logic [1:0] WDT_SLOT       = SLOT_DFU
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_locked_i,
    input  logic       usb_reset_i,
    input  logic       dfu_armed_i,
    input  logic       boot_req_i,
    input  logic [1:0] boot_slot_i,
    input  logic       wdt_kick_i,
    output logic       sys_rst_o,
    output logic [1:0] wb_s_o,
    output logic       wb_boot_o,
    output logic       boot_pending_o
);

    localparam int CNT_MAX = (RST_DELAY > BOOT_DELAY) ? RST_DELAY : BOOT_DELAY;
    localparam int CW      = cnt_width(CNT_MAX);
    localparam int UW      = cnt_width(USB_RST_CYCLES);

    localparam logic [CW-1:0] RST_LOAD  = CW'(RST_DELAY);
    localparam logic [CW-1:0] BOOT_LOAD = CW'(BOOT_DELAY);
    localparam logic [UW-1:0] USB_LAST  = UW'(USB_RST_CYCLES - 1);

    wb_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [UW-1:0] ucnt_q, ucnt_d;
    logic [1:0]    slot_q, slot_d;
    logic          sys_rst_q, sys_rst_d;
    logic          wb_boot_q, wb_boot_d;
    logic          pend_q, pend_d;
    logic          lock_s;
    logic          usb_qual;
    logic          usb_fire;
    logic          wdt_fire;

    sync_2ff u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (pll_locked_i),
        .q_o     (lock_s)
    );

    assign usb_qual = usb_reset_i & dfu_armed_i;
    assign usb_fire = usb_qual && (ucnt_q == USB_LAST);

    // Run length only matters in RUN; firing leaves RUN, so ucnt never exceeds USB_LAST.
    always_comb begin
        ucnt_d = '0;
        if (state_q == RUN && usb_qual && !usb_fire) begin
            ucnt_d = ucnt_q + 1'b1;
        end
    end

`ifdef WARMBOOT_WDT_EN
    localparam int            WW       = cnt_width(WDT_CYCLES);
    localparam logic [WW-1:0] WDT_LOAD = WW'(WDT_CYCLES);

    logic [WW-1:0] wdt_q, wdt_d;

    // Held at the reload value outside RUN, which doubles as the reload on RUN entry.
    always_comb begin
        wdt_d    = WDT_LOAD;
        wdt_fire = 1'b0;
        if (state_q == RUN && !wdt_kick_i) begin
            wdt_d    = (wdt_q != '0) ? wdt_q - 1'b1 : '0;
            wdt_fire = (wdt_q <= WW'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdt_q <= WDT_LOAD;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    localparam int unused_wdt_cfg = WDT_CYCLES + int'(WDT_SLOT);
    logic unused_wdt_kick;

    assign unused_wdt_kick = wdt_kick_i;
    assign wdt_fire        = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        sys_rst_d = sys_rst_q;
        wb_boot_d = wb_boot_q;
        pend_d    = pend_q;
        case (state_q)
            LOCK_WAIT: begin
                sys_rst_d = 1'b1;
                if (lock_s) begin
                    state_d = RST_HOLD;
                    cnt_d   = RST_LOAD;
                end
            end
            RST_HOLD: begin
                if (!lock_s) begin
                    state_d = LOCK_WAIT;
                end else if (cnt_q == '0) begin
                    state_d   = RUN;
                    sys_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d   = LOCK_WAIT;
                    sys_rst_d = 1'b1;
                end else if (boot_req_i || usb_fire || wdt_fire) begin
                    state_d = COUNTDOWN;
                    cnt_d   = BOOT_LOAD;
                    pend_d  = 1'b1;
                    if (boot_req_i) begin
                        slot_d = boot_slot_i;
                    end else if (usb_fire) begin
                        slot_d = USB_SLOT;
                    end else begin
                        slot_d = WDT_SLOT;
                    end
                end
            end
            COUNTDOWN: begin
                if (!lock_s) begin
                    state_d   = LOCK_WAIT;
                    sys_rst_d = 1'b1;
                    pend_d    = 1'b0;
                    slot_d    = USB_SLOT;
                end else if (cnt_q == '0) begin
                    state_d   = BOOT;
                    wb_boot_d = 1'b1;
                    sys_rst_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BOOT: begin
                state_d = BOOT;
            end
            default: begin
                state_d = LOCK_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= LOCK_WAIT;
            cnt_q     <= '0;
            ucnt_q    <= '0;
            slot_q    <= USB_SLOT;
            sys_rst_q <= 1'b1;
            wb_boot_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ucnt_q    <= ucnt_d;
            slot_q    <= slot_d;
            sys_rst_q <= sys_rst_d;
            wb_boot_q <= wb_boot_d;
            pend_q    <= pend_d;
        end
    end

    assign sys_rst_o      = sys_rst_q;
    assign wb_s_o         = slot_q;
    assign wb_boot_o      = wb_boot_q;
    assign boot_pending_o = pend_q;

endmodule

// File: doc/warmboot_ctrl.md
# warmboot_ctrl

Parametrised reset sequencer and warm-boot image selector for the iCE40 badge images. Waits for PLL lock, holds the system in reset for a programmable delay, then triggers `SB_WARMBOOT` to a chosen image slot. Three trigger sources: an explicit request, a qualified USB bus reset while DFU is armed, or an optional watchdog. Sits at top level between the PLL, the USB core/PHY and the `SB_WARMBOOT` primitive.

## Interface
- `RST_DELAY`, 255: cycles `sys_rst` is held after synchronised lock (0 legal)
- `USB_RST_CYCLES`, 16: consecutive qualified `usb_reset` cycles needed to trigger (≥1)
- `BOOT_DELAY`, 64: cycles between trigger and `wb_boot` (0 legal)
- `USB_SLOT`, 2: slot used for USB-reset triggers
- `WDT_CYCLES`, 2^20: watchdog timeout in cycles (≥1)
- `WDT_SLOT`, 1: slot used for watchdog triggers

Ports:
- `clk` in 1: the only clock, 12 MHz system clock
- `rst_n` in 1: asynchronous, active-low reset
- `pll_locked` in 1: PLL lock, asynchronous to `clk`
- `usb_reset` in 1: PHY bus-reset indication, synchronous to `clk`
- `dfu_armed` in 1: DFU core is in appDETACH/manifest; synchronous
- `boot_req` in 1: single-cycle request pulse
- `boot_slot` in 2: slot sampled with `boot_req`
- `wdt_kick` in 1: watchdog reload pulse (ignored without watchdog)
- `sys_rst` out 1: active-high synchronous reset to the rest of the design
- `wb_s` out 2: to `SB_WARMBOOT` `{S1,S0}`
- `wb_boot` out 1: to `SB_WARMBOOT` `BOOT`
- `boot_pending` out 1: high in COUNTDOWN and BOOT

## Operation
- All outputs are registered. Reset values: `sys_rst`=1, `wb_boot`=0, `wb_s`=`USB_SLOT`, `boot_pending`=0. State is LOCK_WAIT.
- `pll_locked` passes through a 2-flop synchroniser to give `lock_s`.
- LOCK_WAIT: when `lock_s` is high, load `cnt`=`RST_DELAY` and go to RST_HOLD.
- RST_HOLD: decrement `cnt`. At `cnt`==0, go to RUN. `lock_s` low returns to LOCK_WAIT.
- RUN: `sys_rst`=0. Triggers, highest priority first:
  - `boot_req` → latch `boot_slot`
  - USB qualifier → `USB_SLOT`
  - watchdog expiry → `WDT_SLOT`
  - Any trigger loads `cnt`=`BOOT_DELAY` and goes to COUNTDOWN. `lock_s` low goes to LOCK_WAIT with `sys_rst`=1, and takes priority over every trigger.
- USB qualifier: `ucnt` increments on each cycle with `usb_reset && dfu_armed`. Any cycle without both clears it to 0. The trigger fires on the `USB_RST_CYCLES`-th consecutive qualified cycle. `ucnt` is cleared outside RUN.
- COUNTDOWN: `wb_s` = latched slot. `sys_rst` stays 0. Decrement `cnt`. At `cnt`==0, go to BOOT. Lock loss aborts to LOCK_WAIT and restores `wb_s`=`USB_SLOT`. New triggers are ignored.
- BOOT: terminal until `rst_n`. `wb_boot`=1, `sys_rst`=1, `wb_s` held stable.
- Counter widths are `$clog2(max+1)` of the parameter they hold. There is no wrap: counters saturate or reload, never roll over.

## Timing
- Take edge 1 as the first edge sampling `pll_locked` high. `lock_s` is high after edge 2. RST_HOLD is entered at edge 3. `sys_rst` falls after edge `RST_DELAY`+4.
- Trigger at edge t: `boot_pending` rises and `wb_s` is valid after edge t. `wb_boot` rises after edge t+`BOOT_DELAY`+1.
- `wb_s` is stable at least `BOOT_DELAY`+1 cycles before `wb_boot` rises, as `SB_WARMBOOT` requires.
- `rst_n` assertion forces the reset values immediately, including mid-countdown.

## Configuration
- `WARMBOOT_WDT_EN` defined: the watchdog counter runs only in RUN and reloads to `WDT_CYCLES` on `wdt_kick` or on RUN entry. It expires on the cycle it reaches 0 with no kick.
- Undefined: there is no watchdog logic and `wdt_kick` is unused. The trigger set is `boot_req` and the USB qualifier only.

## Structure
- `warmboot_pkg`:
  - state enum LOCK_WAIT/RST_HOLD/RUN/COUNTDOWN/BOOT
  - slot constants `SLOT_SPRINGBOARD`=0, `SLOT_DFU`=1, `SLOT_USER`=2
- One sub-module, `sync_2ff`, for `pll_locked`.
- The `SB_WARMBOOT` instance stays at top level, outside this block.

## Test plan
- Lock timing: `RST_DELAY`=10, `pll_locked` high at edge 1 → `sys_rst` low after edge 14; outputs at reset values before that.
- Explicit request: `boot_req` with `boot_slot`=2 at edge t, `BOOT_DELAY`=4 → `wb_s`=2 after t, `wb_boot`=1 after t+5, `sys_rst`=1.
- USB qualifier:
  - `USB_RST_CYCLES`=16, 15 qualified cycles, one gap, then 16 more → trigger on the 16th cycle after the gap only.
  - `dfu_armed`=0 → never triggers.
- Same-cycle priority: `boot_req` (slot 0) and USB qualifier completing on the same cycle → `wb_s`=0.
- Lock loss mid-countdown: drop `pll_locked` during COUNTDOWN → LOCK_WAIT, `sys_rst`=1, `wb_boot` stays 0, `wb_s`=`USB_SLOT`.
- Watchdog (with `WARMBOOT_WDT_EN`, `WDT_CYCLES`=100):
  - kick every 50 cycles → no trigger
  - stop kicking → COUNTDOWN with `wb_s`=1 exactly 100 cycles after the last kick
